// File: rtl/clock_divider_bank.sv
// clock_divider_bank: CHANNELS runtime-reconfigurable integer clock dividers with
// terminal-count strobes, wrap-aligned ratio updates and a startup lock gate.
module clock_divider_bank #(
    parameter int  CHANNELS    = 4,
    parameter int  DIV_W       = 16,
    parameter int  DEFAULT_DIV = 5,
    parameter int  LOCK_CYCLES = 16,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [CHANNELS-1:0] enable_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [DIV_W-1:0]    cfg_div_i,
    output logic                cfg_ack_o,
    output logic                cfg_err_o,
    output logic [CHANNELS-1:0] clk_out_o,
    output logic [CHANNELS-1:0] strobe_o,
    output logic                locked_o
);

    localparam int                LOCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(2);
    localparam logic [CH_W:0]     CH_LIMIT  = (CH_W + 1)'(CHANNELS);

    typedef enum logic {
        CH_IDLE,
        CH_RUN
    } ch_state_e;

    // Lock gate
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    // Configuration handshake
    logic                cfg_ok;
    logic [CHANNELS-1:0] cfg_hit;
    logic                cfg_ack_q, cfg_ack_d;
    logic                cfg_err_q, cfg_err_d;

    // Per-channel divider state
    ch_state_e           state_q [CHANNELS];
    ch_state_e           state_d [CHANNELS];
    logic [DIV_W-1:0]    cnt_q   [CHANNELS];
    logic [DIV_W-1:0]    cnt_d   [CHANNELS];
    logic [DIV_W-1:0]    div_q   [CHANNELS];
    logic [DIV_W-1:0]    div_d   [CHANNELS];
    logic [DIV_W-1:0]    pend_q  [CHANNELS];
    logic [DIV_W-1:0]    pend_d  [CHANNELS];
    logic [CHANNELS-1:0] pend_vld_q, pend_vld_d;
    logic [CHANNELS-1:0] wrap, apply;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] strobe_q, strobe_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
        // Sticky until reset; set on the same edge the counter saturates.
        locked_d = locked_q | (lock_cnt_d == LOCK_MAX);
    end

    always_comb begin
        cfg_ok    = ({1'b0, cfg_ch_i} < CH_LIMIT) && (cfg_div_i >= DIV_MIN);
        cfg_ack_d = cfg_we_i && cfg_ok;
        cfg_err_d = cfg_we_i && !cfg_ok;
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_hit[i] = cfg_ack_d && (cfg_ch_i == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i]  = (state_q[i] == CH_RUN) && (cnt_q[i] == div_q[i] - DIV_ONE);
            apply[i] = pend_vld_q[i] && ((state_q[i] == CH_IDLE) || wrap[i]);
        end
    end

    // NOTE: every next-state signal takes its hold value first so that no
    // path through this block leaves it unassigned and infers a latch.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            div_d[i]      = div_q[i];
            pend_d[i]     = pend_q[i];
            pend_vld_d[i] = pend_vld_q[i];

            // Apply uses the pending value held before this edge; a write landing
            // on the same edge is queued behind it for the next opportunity.
            if (apply[i]) begin
                div_d[i]      = pend_q[i];
                pend_vld_d[i] = 1'b0;
            end
            if (cfg_hit[i]) begin
                pend_d[i]     = cfg_div_i;
                pend_vld_d[i] = 1'b1;
            end

            if (!enable_i[i] || !locked_q) begin
                state_d[i] = CH_IDLE;
                cnt_d[i]   = '0;
            end else if (state_q[i] == CH_IDLE) begin
                state_d[i] = CH_RUN;
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + DIV_ONE;
            end

            // Outputs are derived from the post-edge count and ratio so the flops
            // always agree with the counter in the same cycle.
            clk_out_d[i] = (state_d[i] == CH_RUN) && (cnt_d[i] < (div_d[i] >> 1));
            strobe_d[i]  = (state_d[i] == CH_RUN) && (cnt_d[i] == div_d[i] - DIV_ONE);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            cfg_ack_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            pend_vld_q <= '0;
            clk_out_q  <= '0;
            strobe_q   <= '0;
            // NOTE: the per-channel arrays are small flop banks, not RAM, so each
            // entry is reset explicitly; the default ratio must exist from reset.
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= CH_IDLE;
                cnt_q[i]   <= '0;
                div_q[i]   <= DIV_RST;
                pend_q[i]  <= '0;
            end
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            cfg_ack_q  <= cfg_ack_d;
            cfg_err_q  <= cfg_err_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            strobe_q   <= strobe_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                pend_q[i]  <= pend_d[i];
            end
        end
    end

    assign cfg_ack_o = cfg_ack_q;
    assign cfg_err_o = cfg_err_q;
    assign clk_out_o = clk_out_q;
    assign strobe_o  = strobe_q;
    assign locked_o  = locked_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed self-checking bench for clock_divider_bank: a 4-channel default build
// plus a 3-channel build for out-of-range channel rejects.
module tb_clock_divider_bank;

    logic        clk;
    logic        rst_n;

    logic [3:0]  enable;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_ack, cfg_err, locked;
    logic [3:0]  clk_out, strobe;

    logic [2:0]  enable3;
    logic        cfg_we3;
    logic [1:0]  cfg_ch3;
    logic [15:0] cfg_div3;
    logic        cfg_ack3, cfg_err3, locked3;
    logic [2:0]  clk_out3, strobe3;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_bank #(
        .CHANNELS(4), .DIV_W(16), .DEFAULT_DIV(5), .LOCK_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div),
        .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err),
        .clk_out_o(clk_out), .strobe_o(strobe), .locked_o(locked)
    );

    clock_divider_bank #(
        .CHANNELS(3), .DIV_W(16), .DEFAULT_DIV(5), .LOCK_CYCLES(16)
    ) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable3),
        .cfg_we_i(cfg_we3), .cfg_ch_i(cfg_ch3), .cfg_div_i(cfg_div3),
        .cfg_ack_o(cfg_ack3), .cfg_err_o(cfg_err3),
        .clk_out_o(clk_out3), .strobe_o(strobe3), .locked_o(locked3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs are observed and inputs changed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_strobe(input bit sel3, input int ch, input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            step();
            seen = sel3 ? strobe3[ch] : strobe[ch];
        end
        check("wait_strobe", 32'(seen), 32'd1);
    endtask

    task automatic lock_sequence();
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) check("locked_edge15", 32'(locked), 32'd0);
            if (k == 16) begin
                check("locked_edge16", 32'(locked), 32'd1);
                check("clk_out_at_lock", 32'(clk_out), 32'd0);
            end
        end
    endtask

    // All four main channels running N=5 from cnt=0 in the next cycle.
    task automatic run_default(input int cycles);
        int c;
        for (int j = 0; j < cycles; j++) begin
            step();
            c = j % 5;
            check("default_clk", 32'(clk_out), (c < 2) ? 32'hF : 32'h0);
            check("default_stb", 32'(strobe), (c == 4) ? 32'hF : 32'h0);
        end
    endtask

    initial begin
        int c, k, hi, st;

        rst_n    = 1'b0;
        enable   = 4'hF;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        enable3  = 3'b111;
        cfg_we3  = 1'b0;
        cfg_ch3  = '0;
        cfg_div3 = '0;

        // Reset state
        step();
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_ack_err", 32'({cfg_ack, cfg_err}), 32'd0);
        check("rst_clk_out3", 32'(clk_out3), 32'd0);
        step();
        rst_n = 1'b1;

        // Lock and default ratio on every channel
        lock_sequence();
        run_default(10);

        // Rejects on the 3-channel build, back to back, phase known from strobe
        wait_strobe(1'b1, 0, 20);
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 16'd4;
        for (int j = 0; j <= 10; j++) begin
            step();
            c = j % 5;
            if (j == 0) begin cfg_ch3 = 2'd0; cfg_div3 = 16'd1; end
            if (j == 1) begin cfg_ch3 = 2'd1; cfg_div3 = 16'd0; end
            if (j == 2) cfg_we3 = 1'b0;
            check("rej_err", 32'(cfg_err3), (j < 3) ? 32'd1 : 32'd0);
            check("rej_ack", 32'(cfg_ack3), 32'd0);
            check("rej_clk3", 32'(clk_out3), (c < 2) ? 32'h7 : 32'h0);
            check("rej_stb3", 32'(strobe3), (c == 4) ? 32'h7 : 32'h0);
        end

        // Mid-period reconfig of ch1 to N=4 at cnt=1
        wait_strobe(1'b0, 1, 20);
        step();
        step();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd4;
        for (int j = 0; j <= 10; j++) begin
            step();
            if (j == 0) cfg_we = 1'b0;
            check("mid_ack", 32'(cfg_ack), (j == 0) ? 32'd1 : 32'd0);
            if (j < 3) begin
                check("mid_clk1_old", 32'(clk_out[1]), 32'd0);
                check("mid_stb1_old", 32'(strobe[1]), (j == 2) ? 32'd1 : 32'd0);
            end else begin
                k = (j - 3) % 4;
                check("mid_clk1_new", 32'(clk_out[1]), (k < 2) ? 32'd1 : 32'd0);
                check("mid_stb1_new", 32'(strobe[1]), (k == 3) ? 32'd1 : 32'd0);
            end
            c = (2 + j) % 5;
            check("mid_clk0", 32'(clk_out[0]), (c < 2) ? 32'd1 : 32'd0);
            check("mid_stb0", 32'(strobe[0]), (c == 4) ? 32'd1 : 32'd0);
        end

        // Disable ch2 at cnt=3, write N=7 while idle, re-enable
        wait_strobe(1'b0, 2, 20);
        for (int j = 0; j < 4; j++) step();
        enable[2] = 1'b0;
        step();
        check("dis_clk2", 32'(clk_out[2]), 32'd0);
        check("dis_stb2", 32'(strobe[2]), 32'd0);
        check("dis_stb0", 32'(strobe[0]), 32'd1);
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd7;
        step();
        check("idle_ack", 32'(cfg_ack), 32'd1);
        check("idle_clk2", 32'(clk_out[2]), 32'd0);
        cfg_we = 1'b0;
        enable[2] = 1'b1;
        for (int j = 0; j < 14; j++) begin
            step();
            k = j % 7;
            check("ren_clk2", 32'(clk_out[2]), (k < 3) ? 32'd1 : 32'd0);
            check("ren_stb2", 32'(strobe[2]), (k == 6) ? 32'd1 : 32'd0);
        end

        // Last write wins on ch0, then a write on the wrap edge itself
        wait_strobe(1'b0, 0, 20);
        step();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd6;
        for (int j = 0; j <= 25; j++) begin
            step();
            if (j == 0) cfg_div = 16'd8;
            if (j == 1) cfg_we = 1'b0;
            check("lww_ack", 32'(cfg_ack), (j == 0 || j == 1 || j == 12) ? 32'd1 : 32'd0);
            if (j == 0) begin
                check("lww_clk0", 32'(clk_out[0]), 32'd1);
                check("lww_stb0", 32'(strobe[0]), 32'd0);
            end else if (j < 4) begin
                check("lww_clk0", 32'(clk_out[0]), 32'd0);
                check("lww_stb0", 32'(strobe[0]), (j == 3) ? 32'd1 : 32'd0);
            end else if (j < 20) begin
                k = (j - 4) % 8;
                check("lww_clk0_n8", 32'(clk_out[0]), (k < 4) ? 32'd1 : 32'd0);
                check("lww_stb0_n8", 32'(strobe[0]), (k == 7) ? 32'd1 : 32'd0);
            end else begin
                k = (j - 20) % 3;
                check("wrap_clk0_n3", 32'(clk_out[0]), (k < 1) ? 32'd1 : 32'd0);
                check("wrap_stb0_n3", 32'(strobe[0]), (k == 2) ? 32'd1 : 32'd0);
            end
            if (j == 11) begin
                cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
            end
            if (j == 12) cfg_we = 1'b0;
        end

        // Maximum ratio on ch3
        wait_strobe(1'b0, 3, 20);
        step();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 16'hFFFF;
        step();
        check("max_ack", 32'(cfg_ack), 32'd1);
        cfg_we = 1'b0;
        step();
        step();
        step();
        check("max_old_stb3", 32'(strobe[3]), 32'd1);
        hi = 0;
        st = 0;
        for (int j = 0; j < 65535; j++) begin
            step();
            hi += int'(clk_out[3]);
            st += int'(strobe[3]);
            if (j == 0)     check("max_first_hi", 32'(clk_out[3]), 32'd1);
            if (j == 32766) check("max_last_hi", 32'(clk_out[3]), 32'd1);
            if (j == 32767) check("max_first_lo", 32'(clk_out[3]), 32'd0);
            if (j == 65533) check("max_pre_stb", 32'(strobe[3]), 32'd0);
            if (j == 65534) check("max_stb", 32'(strobe[3]), 32'd1);
        end
        check("max_high_count", 32'(hi), 32'd32767);
        check("max_strobe_count", 32'(st), 32'd1);
        step();
        check("max_wrap_clk3", 32'(clk_out[3]), 32'd1);
        check("max_wrap_stb3", 32'(strobe[3]), 32'd0);

        // Asynchronous reset between edges, relock, defaults restored
        #2 rst_n = 1'b0;
        #1;
        check("async_clk_out", 32'(clk_out), 32'd0);
        check("async_strobe", 32'(strobe), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        check("async_clk_out3", 32'(clk_out3), 32'd0);
        step();
        rst_n = 1'b1;
        lock_sequence();
        run_default(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
